demux_param: RTL and testbench



---
 rtl/demux_pkg.sv | 22 ++
 rtl/demux_lane_counter.sv | 47 ++++
 rtl/demux_param.sv | 109 ++++++++++
 tb/tb_demux_param.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// demux_pkg: shared constants and helpers for the parametrised demux.
//   GAP_DISCARD / GAP_HOLD : values for the GAP_MODE parameter
//   ORDER_LSB / ORDER_MSB  : values for the MSB_FIRST parameter
//   slot_offset()          : low bit index of lane slot within the word
package demux_pkg;

  localparam int GAP_DISCARD = 0;
  localparam int GAP_HOLD    = 1;
  localparam int ORDER_LSB   = 0;
  localparam int ORDER_MSB   = 1;

  // Low bit of slot `slot` in an out_w-bit word built from in_w-bit lanes.
  // MSB order puts slot 0 at the top: bits [out_w-1-slot*in_w -: in_w].
  function automatic int slot_offset(input int slot, input int in_w,
                                     input int out_w, input int order);
    if (order == ORDER_MSB) begin
      return out_w - (slot + 1) * in_w;
    end
    return slot * in_w;
  endfunction

endpackage

// File: rtl/demux_lane_counter.sv
// demux_lane_counter: modulo-RATIO lane counter for demux_param.
// The count value is the assembly state: 0 = empty, 1..RATIO-1 = filling.
//   clk_4f  in   lane clock, rising edge
//   reset_L in   asynchronous active-low reset
//   inc     in   advance one slot (a valid lane was accepted)
//   clr     in   return to slot 0 (partial word dropped); wins over inc
//   cnt     out  current slot, registered
//   wrap    out  high when cnt == RATIO-1 and inc: this lane completes a word
module demux_lane_counter #(
  parameter int RATIO = 4,
  parameter int CW    = $clog2(RATIO)
) (
  input  logic          clk_4f,
  input  logic          reset_L,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          wrap
);

  localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign wrap = inc && (cnt_q == LAST);
  assign cnt  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      // Explicit wrap so non-power-of-two ratios also return to 0.
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/demux_param.sv
// demux_param: serial-to-parallel demultiplexer, RATIO = OUT_W/IN_W lanes
// per output word.
//   clk_4f      in   lane clock, rising edge
//   reset_L     in   asynchronous active-low reset
//   data_in     in   IN_W-bit input lane
//   valid       in   data_in is meaningful this cycle
//   data_out    out  last completed word, held between completions
//   valid_out   out  one-cycle strobe marking a new data_out
//   partial_err out  one-cycle strobe: partial word dropped (DISCARD only)
// Handshake: valid-only, no backpressure. Every cycle with valid = 1 the
// lane is consumed; valid_out / partial_err are registered strobes that the
// consumer must take on the cycle they are high.
module demux_param
  import demux_pkg::*;
#(
  parameter int IN_W      = 8,
  parameter int OUT_W     = 32,
  parameter int MSB_FIRST = 1,
  parameter int GAP_MODE  = 0
) (
  input  logic             clk_4f,
  input  logic             reset_L,
  input  logic [IN_W-1:0]  data_in,
  input  logic             valid,
  output logic [OUT_W-1:0] data_out,
  output logic             valid_out,
  output logic             partial_err
);

  localparam int RATIO = OUT_W / IN_W;
  localparam int CW    = (RATIO >= 2) ? $clog2(RATIO) : 1;

  generate
    if ((OUT_W % IN_W) != 0 || RATIO < 2) begin : g_bad_params
      $error("demux_param: OUT_W must be a multiple of IN_W with RATIO >= 2");
    end
  endgenerate

  logic [CW-1:0]    cnt;
  logic             wrap;
  logic             inc;
  logic             clr;

  logic [OUT_W-1:0] asm_q;
  logic [OUT_W-1:0] asm_d;
  logic [OUT_W-1:0] data_out_q;
  logic [OUT_W-1:0] data_out_d;
  logic             valid_out_q;
  logic             valid_out_d;
  logic             partial_err_q;
  logic             partial_err_d;

  // Gap policy: DISCARD rewinds to slot 0 on any gap inside a word; HOLD
  // simply freezes the counter and the assembly register.
  assign inc = valid;
  assign clr = !valid && (cnt != '0) && (GAP_MODE == GAP_DISCARD);

  demux_lane_counter #(
    .RATIO (RATIO),
    .CW    (CW)
  ) u_lane_counter (
    .clk_4f  (clk_4f),
    .reset_L (reset_L),
    .inc     (inc),
    .clr     (clr),
    .cnt     (cnt),
    .wrap    (wrap)
  );

  always_comb begin
    asm_d         = asm_q;
    data_out_d    = data_out_q;
    valid_out_d   = 1'b0;
    partial_err_d = clr;
    if (valid) begin
      // Stale bits from a dropped word need no clearing: every slot is
      // rewritten before the next completion.
      for (int k = 0; k < RATIO; k++) begin
        if (cnt == CW'(k)) begin
          asm_d[slot_offset(k, IN_W, OUT_W, MSB_FIRST) +: IN_W] = data_in;
        end
      end
    end
    if (wrap) begin
      // asm_d already contains the completing lane.
      data_out_d  = asm_d;
      valid_out_d = 1'b1;
    end
  end

  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      asm_q         <= '0;
      data_out_q    <= '0;
      valid_out_q   <= 1'b0;
      partial_err_q <= 1'b0;
    end else begin
      asm_q         <= asm_d;
      data_out_q    <= data_out_d;
      valid_out_q   <= valid_out_d;
      partial_err_q <= partial_err_d;
    end
  end

  assign data_out    = data_out_q;
  assign valid_out   = valid_out_q;
  assign partial_err = partial_err_q;

endmodule

// File: tb/tb_demux_param.sv
// tb_demux_param: self-checking bench for demux_param. Four instances share
// the clock and reset: defaults (MSB, DISCARD), LSB order, HOLD mode, and a
// 4->16 variant. Expected words are pushed to per-instance queues when the
// completing lane is driven and popped when valid_out is observed.
module tb_demux_param;

  logic        clk;
  logic        rst_n;
  logic [7:0]  data8;
  logic        valid8;
  logic [3:0]  data4;
  logic        valid4;

  logic [31:0] dout_def, dout_lsb, dout_hold;
  logic        vo_def, vo_lsb, vo_hold;
  logic        pe_def, pe_lsb, pe_hold;
  logic [15:0] dout_n4;
  logic        vo_n4, pe_n4;

  logic [31:0] exp_q_def[$];
  logic [31:0] exp_q_lsb[$];
  logic [31:0] exp_q_hold[$];
  logic [15:0] exp_q_n4[$];

  int n_tests;
  int n_fail;

  demux_param u_def (
    .clk_4f(clk), .reset_L(rst_n), .data_in(data8), .valid(valid8),
    .data_out(dout_def), .valid_out(vo_def), .partial_err(pe_def)
  );

  demux_param #(.MSB_FIRST(0)) u_lsb (
    .clk_4f(clk), .reset_L(rst_n), .data_in(data8), .valid(valid8),
    .data_out(dout_lsb), .valid_out(vo_lsb), .partial_err(pe_lsb)
  );

  demux_param #(.GAP_MODE(1)) u_hold (
    .clk_4f(clk), .reset_L(rst_n), .data_in(data8), .valid(valid8),
    .data_out(dout_hold), .valid_out(vo_hold), .partial_err(pe_hold)
  );

  demux_param #(.IN_W(4), .OUT_W(16)) u_n4 (
    .clk_4f(clk), .reset_L(rst_n), .data_in(data4), .valid(valid4),
    .data_out(dout_n4), .valid_out(vo_n4), .partial_err(pe_n4)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic step8(input logic v, input logic [7:0] d);
    valid8 = v;
    data8  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic step4(input logic v, input logic [3:0] d);
    valid4 = v;
    data4  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    valid8 = 1'b0;
    valid4 = 1'b0;
    rst_n  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_q_def.delete();
    exp_q_lsb.delete();
    exp_q_hold.delete();
    exp_q_n4.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n  = 1'b1;
    valid8 = 1'b0;
    valid4 = 1'b0;
    data8  = '0;
    data4  = '0;
    #3;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({dout_def, vo_def, pe_def} !== 34'h0) begin
      n_fail++;
      $display("FAIL reset_def: got %h/%b/%b expected 0/0/0", dout_def, vo_def, pe_def);
    end
    n_tests++;
    if ({dout_lsb, vo_lsb, pe_lsb} !== 34'h0) begin
      n_fail++;
      $display("FAIL reset_lsb: got %h/%b/%b expected 0/0/0", dout_lsb, vo_lsb, pe_lsb);
    end
    n_tests++;
    if ({dout_hold, vo_hold, pe_hold} !== 34'h0) begin
      n_fail++;
      $display("FAIL reset_hold: got %h/%b/%b expected 0/0/0", dout_hold, vo_hold, pe_hold);
    end
    n_tests++;
    if ({dout_n4, vo_n4, pe_n4} !== 18'h0) begin
      n_fail++;
      $display("FAIL reset_n4: got %h/%b/%b expected 0/0/0", dout_n4, vo_n4, pe_n4);
    end
    apply_reset();
  endtask

  // AA BB CC DD on the MSB and LSB instances together.
  task automatic test_lane_order();
    logic [7:0] d [4];
    logic [31:0] e;
    d = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      if (i == 3) begin
        exp_q_def.push_back(32'hAABBCCDD);
        exp_q_lsb.push_back(32'hDDCCBBAA);
      end
      step8(i < 4, (i < 4) ? d[i] : 8'h00);
      n_tests++;
      if (vo_def !== (i == 3) || pe_def !== 1'b0) begin
        n_fail++;
        $display("FAIL order_msb_strobe[%0d]: got vo=%b pe=%b expected vo=%b pe=0", i, vo_def, pe_def, i == 3);
      end
      n_tests++;
      if (vo_lsb !== (i == 3) || pe_lsb !== 1'b0) begin
        n_fail++;
        $display("FAIL order_lsb_strobe[%0d]: got vo=%b pe=%b expected vo=%b pe=0", i, vo_lsb, pe_lsb, i == 3);
      end
      if (vo_def === 1'b1 && exp_q_def.size() > 0) begin
        e = exp_q_def.pop_front();
        n_tests++;
        if (dout_def !== e) begin
          n_fail++;
          $display("FAIL order_msb_data: got %h expected %h", dout_def, e);
        end
      end
      if (vo_lsb === 1'b1 && exp_q_lsb.size() > 0) begin
        e = exp_q_lsb.pop_front();
        n_tests++;
        if (dout_lsb !== e) begin
          n_fail++;
          $display("FAIL order_lsb_data: got %h expected %h", dout_lsb, e);
        end
      end
    end
    // data_out is held after the strobe.
    n_tests++;
    if (dout_def !== 32'hAABBCCDD) begin
      n_fail++;
      $display("FAIL order_msb_hold: got %h expected aabbccdd", dout_def);
    end
  endtask

  // DISCARD: AA BB, gap, 11 22 33 44.
  task automatic test_discard();
    logic [7:0] d [7];
    logic       v [7];
    logic [31:0] e;
    d = '{8'hAA, 8'hBB, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    v = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      if (i == 6) exp_q_def.push_back(32'h11223344);
      step8(v[i], d[i]);
      n_tests++;
      if (pe_def !== (i == 2) || vo_def !== (i == 6)) begin
        n_fail++;
        $display("FAIL discard_strobe[%0d]: got pe=%b vo=%b expected pe=%b vo=%b", i, pe_def, vo_def, i == 2, i == 6);
      end
      if (vo_def === 1'b1 && exp_q_def.size() > 0) begin
        e = exp_q_def.pop_front();
        n_tests++;
        if (dout_def !== e) begin
          n_fail++;
          $display("FAIL discard_data: got %h expected %h", dout_def, e);
        end
      end
    end
  endtask

  // HOLD: AA BB, 3 idle, CC DD, checked against a shift-register model of
  // the legacy 8->32 block (MSB first, gaps freeze).
  task automatic test_hold();
    logic [7:0] d [7];
    logic       v [7];
    logic [31:0] gold_acc;
    int          gold_cnt;
    logic        gold_vo;
    logic [31:0] e;
    d = '{8'hAA, 8'hBB, 8'h00, 8'h00, 8'h00, 8'hCC, 8'hDD};
    v = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    gold_acc = '0;
    gold_cnt = 0;
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      gold_vo = 1'b0;
      if (v[i]) begin
        gold_acc = {gold_acc[23:0], d[i]};
        gold_cnt++;
        if (gold_cnt == 4) begin
          gold_cnt = 0;
          gold_vo  = 1'b1;
          exp_q_hold.push_back(gold_acc);
        end
      end
      step8(v[i], d[i]);
      n_tests++;
      if (vo_hold !== gold_vo || pe_hold !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_strobe[%0d]: got vo=%b pe=%b expected vo=%b pe=0", i, vo_hold, pe_hold, gold_vo);
      end
      if (vo_hold === 1'b1 && exp_q_hold.size() > 0) begin
        e = exp_q_hold.pop_front();
        n_tests++;
        if (dout_hold !== e || dout_hold !== 32'hAABBCCDD) begin
          n_fail++;
          $display("FAIL hold_data: got %h expected %h (aabbccdd)", dout_hold, e);
        end
      end
    end
  endtask

  // 01..08 continuous: two words, strobes 4 cycles apart.
  task automatic test_back_to_back();
    logic [31:0] e;
    int          last_vo;
    int          n_vo;
    apply_reset();
    last_vo = -100;
    n_vo    = 0;
    for (int i = 0; i < 9; i++) begin
      if (i == 3) exp_q_def.push_back(32'h01020304);
      if (i == 7) exp_q_def.push_back(32'h05060708);
      step8(i < 8, 8'(i + 1));
      if (vo_def === 1'b1) begin
        n_vo++;
        if (n_vo == 2) begin
          n_tests++;
          if (i - last_vo != 4) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d cycles expected 4", i - last_vo);
          end
        end
        last_vo = i;
        if (exp_q_def.size() > 0) begin
          e = exp_q_def.pop_front();
          n_tests++;
          if (dout_def !== e) begin
            n_fail++;
            $display("FAIL b2b_data: got %h expected %h", dout_def, e);
          end
        end
      end
    end
    n_tests++;
    if (n_vo != 2 || exp_q_def.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d pulses expected 2", n_vo);
    end
  endtask

  // Gap on the completing lane: AA BB CC, gap, DD EE FF 11.
  task automatic test_gap_on_last();
    logic [7:0] d [8];
    logic       v [8];
    d = '{8'hAA, 8'hBB, 8'hCC, 8'h00, 8'hDD, 8'hEE, 8'hFF, 8'h11};
    v = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      step8(v[i], d[i]);
      n_tests++;
      if (pe_def !== (i == 3) || vo_def !== (i == 7)) begin
        n_fail++;
        $display("FAIL gaplast_def[%0d]: got pe=%b vo=%b expected pe=%b vo=%b", i, pe_def, vo_def, i == 3, i == 7);
      end
      n_tests++;
      if (pe_hold !== 1'b0 || vo_hold !== (i == 4)) begin
        n_fail++;
        $display("FAIL gaplast_hold[%0d]: got pe=%b vo=%b expected pe=0 vo=%b", i, pe_hold, vo_hold, i == 4);
      end
      if (i == 4) begin
        n_tests++;
        if (dout_hold !== 32'hAABBCCDD) begin
          n_fail++;
          $display("FAIL gaplast_hold_data: got %h expected aabbccdd", dout_hold);
        end
      end
    end
    n_tests++;
    if (dout_def !== 32'hDDEEFF11) begin
      n_fail++;
      $display("FAIL gaplast_def_data: got %h expected ddeeff11", dout_def);
    end
  endtask

  // 4->16: complete 5678, then A B, async reset mid-cycle, then 1 2 3 4.
  task automatic test_reset_mid_word();
    logic [15:0] e;
    int          n_vo;
    apply_reset();
    for (int i = 0; i < 4; i++) step4(1'b1, 4'(i + 5));
    n_tests++;
    if (vo_n4 !== 1'b1 || dout_n4 !== 16'h5678) begin
      n_fail++;
      $display("FAIL n4_first: got vo=%b %h expected vo=1 5678", vo_n4, dout_n4);
    end
    step4(1'b1, 4'hA);
    step4(1'b1, 4'hB);
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (dout_n4 !== 16'h0 || vo_n4 !== 1'b0 || pe_n4 !== 1'b0) begin
      n_fail++;
      $display("FAIL n4_async_reset: got %h/%b/%b expected 0/0/0", dout_n4, vo_n4, pe_n4);
    end
    valid4 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_vo = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) exp_q_n4.push_back(16'h1234);
      step4(i < 4, (i < 4) ? 4'(i + 1) : 4'h0);
      n_tests++;
      if (pe_n4 !== 1'b0 || vo_n4 !== (i == 3)) begin
        n_fail++;
        $display("FAIL n4_strobe[%0d]: got pe=%b vo=%b expected pe=0 vo=%b", i, pe_n4, vo_n4, i == 3);
      end
      if (vo_n4 === 1'b1) begin
        n_vo++;
        if (exp_q_n4.size() > 0) begin
          e = exp_q_n4.pop_front();
          n_tests++;
          if (dout_n4 !== e) begin
            n_fail++;
            $display("FAIL n4_data: got %h expected %h", dout_n4, e);
          end
        end
      end
    end
    n_tests++;
    if (n_vo != 1) begin
      n_fail++;
      $display("FAIL n4_pulses: got %0d expected 1", n_vo);
    end
  endtask

  // Random valid/data on the three 8-bit instances against shift models.
  task automatic test_random();
    logic [31:0] acc_m, acc_l, acc_h, e;
    int          k_m, k_l, k_h;
    logic        ev_m, ev_l, ev_h, ep_m, ep_l;
    logic        v;
    logic [7:0]  d;
    apply_reset();
    acc_m = '0; acc_l = '0; acc_h = '0;
    k_m = 0; k_l = 0; k_h = 0;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      d = 8'($urandom_range(0, 255));
      ev_m = 1'b0; ev_l = 1'b0; ev_h = 1'b0; ep_m = 1'b0; ep_l = 1'b0;
      if (v) begin
        acc_m = {acc_m[23:0], d};
        acc_l = {d, acc_l[31:8]};
        acc_h = {acc_h[23:0], d};
        k_m++; k_l++; k_h++;
        if (k_m == 4) begin k_m = 0; ev_m = 1'b1; exp_q_def.push_back(acc_m); end
        if (k_l == 4) begin k_l = 0; ev_l = 1'b1; exp_q_lsb.push_back(acc_l); end
        if (k_h == 4) begin k_h = 0; ev_h = 1'b1; exp_q_hold.push_back(acc_h); end
      end else begin
        if (k_m != 0) begin k_m = 0; ep_m = 1'b1; end
        if (k_l != 0) begin k_l = 0; ep_l = 1'b1; end
      end
      step8(v, d);
      n_tests++;
      if (vo_def !== ev_m || pe_def !== ep_m || vo_lsb !== ev_l || pe_lsb !== ep_l ||
          vo_hold !== ev_h || pe_hold !== 1'b0) begin
        n_fail++;
        $display("FAIL rand_strobe[%0d]: got %b%b %b%b %b%b expected %b%b %b%b %b0", i,
                 vo_def, pe_def, vo_lsb, pe_lsb, vo_hold, pe_hold, ev_m, ep_m, ev_l, ep_l, ev_h);
      end
      if (vo_def === 1'b1 && exp_q_def.size() > 0) begin
        e = exp_q_def.pop_front();
        n_tests++;
        if (dout_def !== e) begin
          n_fail++;
          $display("FAIL rand_def_data: got %h expected %h", dout_def, e);
        end
      end
      if (vo_lsb === 1'b1 && exp_q_lsb.size() > 0) begin
        e = exp_q_lsb.pop_front();
        n_tests++;
        if (dout_lsb !== e) begin
          n_fail++;
          $display("FAIL rand_lsb_data: got %h expected %h", dout_lsb, e);
        end
      end
      if (vo_hold === 1'b1 && exp_q_hold.size() > 0) begin
        e = exp_q_hold.pop_front();
        n_tests++;
        if (dout_hold !== e) begin
          n_fail++;
          $display("FAIL rand_hold_data: got %h expected %h", dout_hold, e);
        end
      end
    end
    n_tests++;
    if (exp_q_def.size() != 0 || exp_q_lsb.size() != 0 || exp_q_hold.size() != 0) begin
      n_fail++;
      $display("FAIL rand_leftover: got %0d/%0d/%0d queued expected 0/0/0",
               exp_q_def.size(), exp_q_lsb.size(), exp_q_hold.size());
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_lane_order();
    test_discard();
    test_hold();
    test_back_to_back();
    test_gap_on_last();
    test_reset_mid_word();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
